// File: rtl/acc_sequencer.sv
// acc_sequencer: multi-cycle fetch/decode/execute/memory/writeback control for the accumulator datapath.
// Every output except ir_load is a flop loaded from the decode of the next state and the next latched control.
module acc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] op,
    input  logic [2:0] acc_ctl,
    input  logic       eq_flag,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_load,
    output logic       acc_we,
    output logic       reg_we,
    output logic       flag_we,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       flag,
    output logic       busy,
    output logic       halted,
    output logic       err,
    output logic [7:0] instret
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam logic [2:0] CTL_NONE  = 3'b000;
    localparam logic [2:0] CTL_ACC   = 3'b001;
    localparam logic [2:0] CTL_UNARY = 3'b010;
    localparam logic [2:0] CTL_EQ    = 3'b011;
    localparam logic [2:0] CTL_JMP   = 3'b100;
    localparam logic [2:0] CTL_STORE = 3'b101;
    localparam logic [2:0] CTL_LOAD  = 3'b110;
    localparam logic [2:0] CTL_LWRI  = 3'b111;
    localparam logic [5:0] OP_HALT   = 6'b000111;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 32'd1);

    state_t     state_q, state_d;
    logic [2:0] ctl_q, ctl_d;
    logic       flag_q, flag_d;
    logic [7:0] instret_q, instret_d;
    logic [7:0] wait_q, wait_d;

    logic imem_req_q, imem_req_d;
    logic dmem_req_q, dmem_req_d;
    logic dmem_we_q, dmem_we_d;
    logic acc_we_q, acc_we_d;
    logic reg_we_q, reg_we_d;
    logic flag_we_q, flag_we_d;
    logic pc_inc_q, pc_inc_d;
    logic pc_load_q, pc_load_d;
    logic busy_q, busy_d;
    logic halted_q, halted_d;
    logic err_q, err_d;

    // Next-state, control latch, flag, retire counter and memory wait counter
    always_comb begin
        state_d   = state_q;
        ctl_d     = ctl_q;
        flag_d    = flag_q;
        instret_d = instret_q;
        wait_d    = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    wait_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // an ack arriving on the last allowed wait cycle still wins
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                ctl_d = acc_ctl;
                if (acc_ctl == CTL_NONE) begin
                    state_d = (op == OP_HALT) ? ST_HALT : ST_ERR;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ctl_q == CTL_EQ) begin
                    flag_d = eq_flag;
                end else begin
                    flag_d = flag_q;
                end
                if ((ctl_q == CTL_STORE) || (ctl_q == CTL_LOAD)) begin
                    state_d = ST_MEM;
                    wait_d  = 8'd0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WB: begin
                instret_d = instret_q + 8'd1;
                state_d   = ST_FETCH;
                wait_d    = 8'd0;
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Output decode from the upcoming state so the flops present Moore values without a cycle of lag
    always_comb begin
        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && (ctl_d == CTL_STORE);
        flag_we_d  = (state_d == ST_EXEC) && (ctl_d == CTL_EQ);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_HALT) && (state_d != ST_ERR);
        halted_d   = (state_d == ST_HALT);
        err_d      = (state_d == ST_ERR);
        if (state_d == ST_WB) begin
            acc_we_d  = (ctl_d == CTL_ACC) || (ctl_d == CTL_UNARY) || (ctl_d == CTL_LOAD);
            reg_we_d  = (ctl_d == CTL_LWRI);
            pc_load_d = (ctl_d == CTL_JMP) && flag_d;
            pc_inc_d  = !((ctl_d == CTL_JMP) && flag_d);
        end else begin
            acc_we_d  = 1'b0;
            reg_we_d  = 1'b0;
            pc_load_d = 1'b0;
            pc_inc_d  = 1'b0;
        end
    end

    // State, datapath-control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctl_q      <= 3'b000;
            flag_q     <= 1'b0;
            instret_q  <= 8'd0;
            wait_q     <= 8'd0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            acc_we_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            flag_we_q  <= 1'b0;
            pc_inc_q   <= 1'b0;
            pc_load_q  <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctl_q      <= ctl_d;
            flag_q     <= flag_d;
            instret_q  <= instret_d;
            wait_q     <= wait_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            acc_we_q   <= acc_we_d;
            reg_we_q   <= reg_we_d;
            flag_we_q  <= flag_we_d;
            pc_inc_q   <= pc_inc_d;
            pc_load_q  <= pc_load_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    // The IR must capture the bus in the very cycle the instruction is valid
    assign ir_load  = (state_q == ST_FETCH) && imem_ack;
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign acc_we   = acc_we_q;
    assign reg_we   = reg_we_q;
    assign flag_we  = flag_we_q;
    assign pc_inc   = pc_inc_q;
    assign pc_load  = pc_load_q;
    assign flag     = flag_q;
    assign busy     = busy_q;
    assign halted   = halted_q;
    assign err      = err_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: per-instruction expected output traces built from the phase/latency rules,
// driven with random control modes, ack delays and stray acks.
module tb_acc_sequencer;

    localparam int TO = 16;

    localparam logic [12:0] V_IMR = 13'h1000;
    localparam logic [12:0] V_DMR = 13'h0800;
    localparam logic [12:0] V_DWE = 13'h0400;
    localparam logic [12:0] V_IRL = 13'h0200;
    localparam logic [12:0] V_ACC = 13'h0100;
    localparam logic [12:0] V_REG = 13'h0080;
    localparam logic [12:0] V_FLW = 13'h0040;
    localparam logic [12:0] V_PCI = 13'h0020;
    localparam logic [12:0] V_PCL = 13'h0010;
    localparam logic [12:0] V_FLG = 13'h0008;
    localparam logic [12:0] V_BSY = 13'h0004;
    localparam logic [12:0] V_HLT = 13'h0002;
    localparam logic [12:0] V_ERR = 13'h0001;
    localparam logic [5:0]  OP_HALT = 6'b000111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, imem_ack, dmem_ack, eq_flag;
    logic [5:0] op;
    logic [2:0] acc_ctl;
    logic       imem_req, dmem_req, dmem_we, ir_load, acc_we, reg_we, flag_we;
    logic       pc_inc, pc_load, flag, busy, halted, err;
    logic [7:0] instret;

    int         n_total = 0;
    int         n_bad = 0;
    bit         exp_flag;
    logic [7:0] exp_instret;

    acc_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .acc_ctl(acc_ctl),
        .eq_flag(eq_flag), .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir_load(ir_load), .acc_we(acc_we), .reg_we(reg_we), .flag_we(flag_we),
        .pc_inc(pc_inc), .pc_load(pc_load), .flag(flag), .busy(busy),
        .halted(halted), .err(err), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] obs_vec();
        return {instret, imem_req, dmem_req, dmem_we, ir_load, acc_we, reg_we,
                flag_we, pc_inc, pc_load, flag, busy, halted, err};
    endfunction

    // Inputs for the current cycle are already driven; check mid-cycle, then move to just after the next edge.
    task automatic step(input logic [12:0] ev, input string tag);
        @(negedge clk);
        chk_val(tag, {11'd0, obs_vec()},
                {11'd0, exp_instret, ev | (exp_flag ? V_FLG : 13'd0)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        acc_ctl = 3'b000; op = 6'd0; eq_flag = 1'b0;
        #3;
        chk_val("reset", {11'd0, obs_vec()}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_flag = 1'b0;
        exp_instret = 8'd0;
    endtask

    task automatic start_run();
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
        start = 1'b0;
        step(13'd0, "idle_hold");
        start = 1'b1;
        step(13'd0, "idle_start");
    endtask

    task automatic sit_in(input logic [12:0] ev, input string tag);
        for (int k = 0; k < 4; k++) begin
            start = 1'b1; imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            step(ev, tag);
        end
    endtask

    // One instruction; delays >= TO model a missing ack, rst_mem >= 0 pulls reset in that MEM cycle.
    task automatic do_instr(input logic [2:0] ctl, input logic [5:0] opc, input bit eqf,
                            input int fdel, input int mdel, input int rst_mem);
        logic [12:0] ev;
        bit          pcl;
        acc_ctl = ctl; op = opc; eq_flag = eqf;
        for (int i = 0; i < TO; i++) begin
            imem_ack = (i == fdel); dmem_ack = 1'($urandom); start = 1'($urandom);
            step(V_IMR | V_BSY | ((i == fdel) ? V_IRL : 13'd0), "fetch");
            if (i == fdel) break;
        end
        if (fdel >= TO) begin
            sit_in(V_ERR, "fetch_timeout");
            return;
        end
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
        step(V_BSY, "decode");
        acc_ctl = 3'($urandom); op = 6'($urandom);
        if (ctl == 3'b000) begin
            if (opc == OP_HALT) sit_in(V_HLT, "halt");
            else sit_in(V_ERR, "illegal");
            return;
        end
        step(V_BSY | ((ctl == 3'b011) ? V_FLW : 13'd0), "exec");
        eq_flag = 1'($urandom);
        if (ctl == 3'b011) exp_flag = eqf;
        if ((ctl == 3'b101) || (ctl == 3'b110)) begin
            for (int i = 0; i < TO; i++) begin
                if (i == rst_mem) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk_val("rst_mid_mem", {11'd0, obs_vec()}, 32'd0);
                    return;
                end
                dmem_ack = (i == mdel); imem_ack = 1'($urandom);
                step(V_DMR | V_BSY | ((ctl == 3'b101) ? V_DWE : 13'd0), "mem");
                if (i == mdel) break;
            end
            if (mdel >= TO) begin
                sit_in(V_ERR, "mem_timeout");
                return;
            end
        end
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
        pcl = (ctl == 3'b100) && exp_flag;
        ev = V_BSY | (pcl ? V_PCL : V_PCI);
        if ((ctl == 3'b001) || (ctl == 3'b010) || (ctl == 3'b110)) ev = ev | V_ACC;
        if (ctl == 3'b111) ev = ev | V_REG;
        step(ev, "wb");
        exp_instret = exp_instret + 8'd1;
    endtask

    function automatic int rand_delay();
        return ($urandom_range(0, 7) == 0) ? (TO - 1) : int'($urandom_range(0, 3));
    endfunction

    task automatic rand_instr();
        do_instr(3'($urandom_range(1, 7)), 6'($urandom), 1'($urandom),
                 rand_delay(), rand_delay(), -1);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        acc_ctl = 3'b000; op = 6'd0; eq_flag = 1'b0;
        exp_flag = 1'b0; exp_instret = 8'd0;
        #2;
        do_reset();
        start_run();
        do_instr(3'b001, 6'h2a, 1'b0, 0, 0, -1);
        do_instr(3'b110, 6'h11, 1'b0, 0, 3, -1);
        do_instr(3'b011, 6'h05, 1'b1, 0, 0, -1);
        do_instr(3'b100, 6'h30, 1'b0, 0, 0, -1);
        do_instr(3'b011, 6'h05, 1'b0, 1, 0, -1);
        do_instr(3'b100, 6'h30, 1'b1, 0, 0, -1);
        do_instr(3'b101, 6'h21, 1'b0, 2, 0, -1);
        do_instr(3'b111, 6'h3f, 1'b0, 0, 0, -1);
        do_instr(3'b010, 6'h0c, 1'b0, TO - 1, 0, -1);
        do_instr(3'b110, 6'h12, 1'b0, 0, TO - 1, -1);
        for (int n = 0; n < 40; n++) rand_instr();

        do_instr(3'b000, OP_HALT, 1'b0, 1, 0, -1);
        do_reset();
        start_run();
        do_instr(3'b001, 6'h01, 1'b0, 0, 0, -1);
        do_instr(3'b000, 6'h15, 1'b0, 0, 0, -1);
        do_reset();
        start_run();
        do_instr(3'b001, 6'h01, 1'b0, TO, 0, -1);
        do_reset();
        start_run();
        do_instr(3'b101, 6'h22, 1'b0, 0, TO, -1);
        do_reset();
        start_run();
        do_instr(3'b110, 6'h23, 1'b0, 0, 10, 2);
        do_reset();
        start_run();
        for (int n = 0; n < 256; n++) begin
            do_instr(3'($urandom_range(1, 7)), 6'($urandom), 1'($urandom),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), -1);
        end
        chk_val("instret_wrap", {24'd0, instret}, {24'd0, exp_instret});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
